// File: rtl/mem_loader_pkg.sv
// mem_loader shared types: FSM states, error causes
// and the wrap-around checksum helper.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    VERIFY,
    DONE,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_LEN      = 2'd1,
    ERR_STREAM   = 2'd2,
    ERR_READBACK = 2'd3
  } err_t;

  // Modular add truncated to w bits; caller narrows the result.
  function automatic logic [63:0] csum_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input int          w
  );
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (a + b) & m;
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Stream input plus memory port bundle for mem_loader.
// slave = loader side, master = stream source / memory side.
interface mem_loader_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  s_valid;
  logic [WIDTH-1:0]      s_data;
  logic                  s_ready;
  logic                  mem_wr_en;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wr_data;
  logic [WIDTH-1:0]      mem_rd_data;

  modport slave (
    input  s_valid, s_data, mem_rd_data,
    output s_ready, mem_wr_en, mem_rd_en,
    output mem_addr, mem_wr_data
  );

  modport master (
    output s_valid, s_data, mem_rd_data,
    input  s_ready, mem_wr_en, mem_rd_en,
    input  mem_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_loader.sv
// Boot loader: streams an image into memory, then
// reads it back and verifies it against a checksum.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_WIDTH:0] length,
  mem_loader_if.slave         bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_cause
);

  localparam logic [ADDR_WIDTH:0] ONE     = 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state_q;
  err_t                cause_q;
  logic [ADDR_WIDTH:0] cnt_q;
  logic [ADDR_WIDTH:0] len_q;
  logic [WIDTH-1:0]    sum_q;
  logic [WIDTH-1:0]    rsum_q;
  logic [WIDTH-1:0]    exp_q;
  logic                ok_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;

  logic             hs;
  logic             last;
  logic             bad_len;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] rsum_d;

  assign bus.s_ready = !rst &&
    (state_q == LOAD || state_q == CHECK);
  assign bus.mem_wr_en = !rst &&
    state_q == LOAD && bus.s_valid;
  assign bus.mem_rd_en = !rst && state_q == VERIFY;
  assign bus.mem_addr    = cnt_q[ADDR_WIDTH-1:0];
  assign bus.mem_wr_data = bus.s_data;

  assign hs      = bus.s_valid && bus.s_ready;
  assign last    = cnt_q == len_q - ONE;
  assign bad_len = length == '0 || length > DEPTH_L;

  assign sum_d = WIDTH'(csum_add(
    64'(sum_q), 64'(bus.s_data), WIDTH));
  assign rsum_d = WIDTH'(csum_add(
    64'(rsum_q), 64'(bus.mem_rd_data), WIDTH));

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_cause = cause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= ERR_NONE;
      cnt_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      rsum_q  <= '0;
      exp_q   <= '0;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (start && bad_len) begin
            state_q <= ERROR;
            cause_q <= ERR_LEN;
            done_q  <= 1'b0;
            error_q <= 1'b1;
          end else if (start) begin
            state_q <= LOAD;
            cause_q <= ERR_NONE;
            len_q   <= length;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        LOAD: begin
          if (hs) begin
            sum_q <= sum_d;
            if (last) begin
              state_q <= CHECK;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
        end
        CHECK: begin
          if (hs) begin
            exp_q   <= bus.s_data;
            ok_q    <= sum_q == bus.s_data;
            cnt_q   <= '0;
            rsum_q  <= '0;
            state_q <= VERIFY;
          end
        end
        VERIFY: begin
          rsum_q <= rsum_d;
          if (last) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            // stream mismatch outranks readback mismatch
            if (!ok_q) begin
              state_q <= ERROR;
              cause_q <= ERR_STREAM;
              error_q <= 1'b1;
            end else if (rsum_d != exp_q) begin
              state_q <= ERROR;
              cause_q <= ERR_READBACK;
              error_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Randomised self-checking bench for mem_loader with
// a memory model and an image-level reference model.
module tb_mem_loader;
  import mem_loader_pkg::*;

  localparam int W     = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef logic [W-1:0] word_q_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_cause;

  mem_loader_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  mem_loader #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .length   (length),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [DEPTH];
  bit           fault;

  always @(posedge clk)
    if (bus.mem_wr_en)
      mem[bus.mem_addr] <= (fault && bus.mem_addr == 2) ?
        (bus.mem_wr_data & ~32'h1) : bus.mem_wr_data;

  assign bus.mem_rd_data = mem[bus.mem_addr];

  int checks = 0;
  int errors = 0;

  int           busy_cnt;
  logic [AW-1:0] wr_addr[$];
  logic [W-1:0]  wr_data[$];
  logic [AW-1:0] rd_addr[$];

  always @(negedge clk) begin
    if (bus.mem_wr_en) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wr_data);
    end
    if (bus.mem_rd_en) rd_addr.push_back(bus.mem_addr);
    if (busy) busy_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    rd_addr.delete();
    busy_cnt = 0;
  endtask

  // Outcome of a load from the image, the supplied checksum
  // and the memory's stuck-bit fault.
  function automatic int model_cause(
    input word_q_t d, input logic [W-1:0] ck, input bit flt);
    logic [W-1:0] s = '0;
    logic [W-1:0] r = '0;
    foreach (d[i]) begin
      s = s + d[i];
      r = r + ((flt && i == 2) ? (d[i] & ~32'h1) : d[i]);
    end
    if (s != ck) return 2;
    if (r != ck) return 3;
    return 0;
  endfunction

  function automatic logic [W-1:0] model_sum(input word_q_t d);
    logic [W-1:0] s = '0;
    foreach (d[i]) s = s + d[i];
    return s;
  endfunction

  // mode: 0 no gaps, 1 one gap before each later word,
  // 2 random gaps. glitch pulses start while busy.
  task automatic run_load(
    input int n, input word_q_t d, input logic [W-1:0] ck,
    input int mode, input bit glitch, input string name);
    word_q_t words;
    int      gaps = 0;
    int      guard;
    int      exp_c;
    bit      hs;
    bit      gapped;
    words = d;
    words.push_back(ck);
    exp_c = model_cause(d, ck, fault);
    clear_log();
    start  = 1'b1;
    length = (AW+1)'(n);
    step();
    start = 1'b0;
    for (int i = 0; i <= n; i++) begin
      hs = 1'b0;
      gapped = 1'b0;
      guard = 0;
      while (!hs) begin
        if ((mode == 1 && i > 0 && !gapped) ||
            (mode == 2 && $urandom_range(99) < 30)) begin
          bus.s_valid = 1'b0;
          bus.s_data  = $urandom;
          gapped = 1'b1;
          gaps++;
        end else begin
          bus.s_valid = 1'b1;
          bus.s_data  = words[i];
        end
        if (glitch && i == 1) begin
          start  = 1'b1;
          length = '0;
        end
        @(negedge clk);
        hs = bus.s_valid && bus.s_ready;
        step();
        start = 1'b0;
        guard++;
        if (!hs && guard > 200) begin
          errors++;
          $display("FAIL %s handshake timeout word %0d", name, i);
          bus.s_valid = 1'b0;
          return;
        end
      end
    end
    bus.s_valid = 1'b0;
    guard = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      guard++;
      if (guard > 4 * n + 20) begin
        checks++;
        errors++;
        $display("FAIL %s busy timeout", name);
        step();
        return;
      end
    end
    checks++;
    if (err_cause !== 2'(exp_c) || done !== (exp_c == 0) ||
        error !== (exp_c != 0)) begin
      errors++;
      $display("FAIL %s outcome got d=%b e=%b c=%0d exp c=%0d",
               name, done, error, err_cause, exp_c);
    end
    checks++;
    if (busy_cnt != 2 * n + 1 + gaps) begin
      errors++;
      $display("FAIL %s busy cycles got %0d exp %0d",
               name, busy_cnt, 2 * n + 1 + gaps);
    end
    checks++;
    if (wr_addr.size() != n || rd_addr.size() != n) begin
      errors++;
      $display("FAIL %s access count wr %0d rd %0d exp %0d",
               name, wr_addr.size(), rd_addr.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wr_addr[i] !== AW'(i) || wr_data[i] !== d[i] ||
            rd_addr[i] !== AW'(i)) begin
          errors++;
          $display("FAIL %s access %0d wa=%0d wd=%h ra=%0d exp %h",
                   name, i, wr_addr[i], wr_data[i], rd_addr[i], d[i]);
        end
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    length = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    step();
    step();
    @(negedge clk);
    checks++;
    if (busy !== 0 || done !== 0 || error !== 0 ||
        err_cause !== 0) begin
      errors++;
      $display("FAIL reset status b=%b d=%b e=%b c=%0d exp 0",
               busy, done, error, err_cause);
    end
    checks++;
    if (bus.s_ready !== 0 || bus.mem_wr_en !== 0 ||
        bus.mem_rd_en !== 0 || bus.mem_addr !== 0) begin
      errors++;
      $display("FAIL reset bus rdy=%b we=%b re=%b a=%0d exp 0",
               bus.s_ready, bus.mem_wr_en, bus.mem_rd_en,
               bus.mem_addr);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    run_load(4, '{32'h1, 32'h2, 32'h3, 32'h4}, 32'hA, 0, 0,
             "nominal");
  endtask

  task automatic test_stream_mismatch();
    run_load(4, '{32'h1, 32'h2, 32'h3, 32'h4}, 32'hB, 0, 0,
             "stream_mismatch");
  endtask

  task automatic test_readback_fault();
    fault = 1'b1;
    run_load(4, '{32'h1, 32'h2, 32'h3, 32'h4}, 32'hA, 0, 0,
             "readback_fault");
    fault = 1'b0;
  endtask

  task automatic test_bad_length();
    int lens[3] = '{0, DEPTH + 1, 2 * DEPTH - 1};
    foreach (lens[k]) begin
      clear_log();
      start  = 1'b1;
      length = (AW+1)'(lens[k]);
      step();
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (error !== 1 || done !== 0 || busy !== 0 ||
          err_cause !== 2'd1) begin
        errors++;
        $display("FAIL bad_len %0d e=%b d=%b b=%b c=%0d",
                 lens[k], error, done, busy, err_cause);
      end
      step();
      checks++;
      if (wr_addr.size() != 0 || busy_cnt != 0) begin
        errors++;
        $display("FAIL bad_len %0d writes %0d busy %0d exp 0",
                 lens[k], wr_addr.size(), busy_cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    run_load(3, '{32'hFFFF_FFFF, 32'h2, 32'h0}, 32'h1, 1, 0,
             "backpressure_wrap");
  endtask

  task automatic test_reset_mid();
    word_q_t d;
    clear_log();
    start  = 1'b1;
    length = 5'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = $urandom;
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_wr_en !== 0) begin
      errors++;
      $display("FAIL reset_mid wr_en in rst got %b exp 0",
               bus.mem_wr_en);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 0 || bus.s_ready !== 0 ||
        bus.mem_wr_en !== 0 || wr_addr.size() != 2) begin
      errors++;
      $display("FAIL reset_mid b=%b rdy=%b we=%b writes=%0d",
               busy, bus.s_ready, bus.mem_wr_en, wr_addr.size());
    end
    step();
    bus.s_valid = 1'b0;
    d = '{$urandom, $urandom};
    run_load(2, d, model_sum(d), 0, 0, "reset_mid_reload");
  endtask

  task automatic test_busy_start();
    word_q_t d;
    for (int i = 0; i < 5; i++) d.push_back($urandom);
    run_load(5, d, model_sum(d), 0, 1, "start_while_busy");
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      word_q_t      d;
      logic [W-1:0] ck;
      int           n;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) d.push_back($urandom);
      ck = model_sum(d);
      if ($urandom_range(99) < 30)
        ck = ck + W'($urandom_range(1, 1000));
      fault = (n > 2) && ($urandom_range(99) < 20);
      run_load(n, d, ck, 2, 0, "random");
      fault = 1'b0;
    end
  endtask

  task automatic test_full_depth();
    word_q_t d;
    for (int i = 0; i < DEPTH; i++) d.push_back($urandom);
    run_load(DEPTH, d, model_sum(d), 0, 0, "full_depth");
  endtask

  initial begin
    fault = 1'b0;
    test_reset();
    test_nominal();
    test_bad_length();
    test_stream_mismatch();
    test_readback_fault();
    test_backpressure();
    test_reset_mid();
    test_busy_start();
    test_random();
    test_full_depth();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
